// File: rtl/framebuf_pingpong_ctrl.sv
// Ping-pong frame buffer controller: writes incoming pixels into one bank
// while streaming the previous frame out of the other. Banks swap once the
// current write frame is complete and the read frame has fully returned.
module framebuf_pingpong_ctrl #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 32,
  parameter int FRAME_PIXELS = 153600,
  parameter int RD_DEPTH     = 8
)(
  input  logic              clk,
  input  logic              reset_n,
  // upstream pixel stream
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  // downstream pixel stream
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  input  logic              out_ready,
  // frame-buffer bus, write side
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_write_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_write_done,
  // frame-buffer bus, read side
  output logic              bus_read,
  output logic [ADDR_W-1:0] bus_read_addr,
  input  logic              bus_read_done,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  // status
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [15:0]       swap_cnt,
  output logic              err_rvalid
);

  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  generate
    if ((64'(2) * 64'(FRAME_PIXELS)) > (64'(1) << ADDR_W)) begin : g_bad_addr_w
      $error("framebuf_pingpong_ctrl: two frames do not fit in ADDR_W");
    end
    if (RD_DEPTH < 2 || (RD_DEPTH & (RD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("framebuf_pingpong_ctrl: RD_DEPTH must be a power of 2, >= 2");
    end
  endgenerate

  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } rd_entry_t;

  function automatic logic [ADDR_W-1:0] bank_base(input logic b);
    return b ? ADDR_W'(FRAME_PIXELS) : '0;
  endfunction

  // state
  logic             wr_frame_done, rd_active, first_ret;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [OCC_W-1:0] rd_out, fifo_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  rd_entry_t        fifo_mem [RD_DEPTH];

  // combinational controls
  logic             wr_accept, wr_fire, rd_fire, rd_ret, pop, swap, rd_frame_done;
  logic             rd_issue, rd_active_nxt, rd_bank_nxt;
  logic [CNT_W-1:0] rd_cnt_nxt;
  logic [OCC_W-1:0] rd_out_nxt, fifo_cnt_nxt;

  // bus_write doubles as the write-busy flag: one write in flight at a time
  assign in_ready      = !bus_write && !wr_frame_done;
  assign wr_accept     = in_valid && in_ready;
  assign wr_fire       = bus_write && bus_write_done;
  assign rd_fire       = bus_read && bus_read_done;
  assign rd_ret        = bus_rvalid && (rd_out != '0);
  assign out_valid     = (fifo_cnt != '0);
  assign pop           = out_valid && out_ready;
  assign rd_frame_done = (rd_cnt == CNT_W'(FRAME_PIXELS)) && (rd_out == '0);
  assign swap          = wr_frame_done && (rd_frame_done || !rd_active);

  assign out_data = fifo_mem[rd_ptr].data;
  assign out_sof  = out_valid && fifo_mem[rd_ptr].sof;

  // Next-state of the read bookkeeping; the issue decision looks at the
  // post-edge occupancy so a granted request can never overfill the FIFO.
  always_comb begin
    rd_cnt_nxt    = rd_cnt;
    rd_out_nxt    = rd_out;
    fifo_cnt_nxt  = fifo_cnt;
    rd_active_nxt = rd_active;
    rd_bank_nxt   = rd_bank;
    if (rd_fire) rd_cnt_nxt = rd_cnt + 1'b1;
    if (rd_fire && !rd_ret)      rd_out_nxt = rd_out + 1'b1;
    else if (!rd_fire && rd_ret) rd_out_nxt = rd_out - 1'b1;
    if (rd_ret && !pop)      fifo_cnt_nxt = fifo_cnt + 1'b1;
    else if (!rd_ret && pop) fifo_cnt_nxt = fifo_cnt - 1'b1;
    if (swap) begin
      rd_cnt_nxt    = '0;
      rd_active_nxt = 1'b1;
      rd_bank_nxt   = wr_bank;
    end
    rd_issue = rd_active_nxt && (!bus_read || rd_fire) &&
               (rd_cnt_nxt < CNT_W'(FRAME_PIXELS)) &&
               (({1'b0, rd_out_nxt} + {1'b0, fifo_cnt_nxt}) < (OCC_W + 1)'(RD_DEPTH));
  end

  // Write path: latch pixel, hold request until done, count the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_write      <= 1'b0;
      bus_write_addr <= '0;
      bus_wdata      <= '0;
      wr_cnt         <= '0;
      wr_frame_done  <= 1'b0;
    end else begin
      if (wr_accept) begin
        bus_write      <= 1'b1;
        bus_write_addr <= bank_base(wr_bank) + ADDR_W'(wr_cnt);
        bus_wdata      <= in_data;
      end else if (wr_fire) begin
        bus_write <= 1'b0;
      end
      if (swap) begin
        wr_cnt        <= '0;
        wr_frame_done <= 1'b0;
      end else if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == CNT_W'(FRAME_PIXELS - 1)) wr_frame_done <= 1'b1;
      end
    end
  end

  // Read path, bank swap and error tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b1;
      rd_active     <= 1'b0;
      rd_cnt        <= '0;
      rd_out        <= '0;
      first_ret     <= 1'b0;
      bus_read      <= 1'b0;
      bus_read_addr <= '0;
      swap_cnt      <= '0;
      err_rvalid    <= 1'b0;
    end else begin
      rd_cnt    <= rd_cnt_nxt;
      rd_out    <= rd_out_nxt;
      rd_active <= rd_active_nxt;
      rd_bank   <= rd_bank_nxt;
      if (swap) begin
        wr_bank  <= ~wr_bank;
        swap_cnt <= swap_cnt + 1'b1;
      end
      if (rd_issue) begin
        bus_read      <= 1'b1;
        bus_read_addr <= bank_base(rd_bank_nxt) + ADDR_W'(rd_cnt_nxt);
      end else if (rd_fire) begin
        bus_read <= 1'b0;
      end
      if (bus_rvalid && (rd_out == '0)) err_rvalid <= 1'b1;
      if (swap)        first_ret <= 1'b1;
      else if (rd_ret) first_ret <= 1'b0;
    end
  end

  // Read-return FIFO, show-ahead head; contents survive a bank swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RD_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      fifo_cnt <= fifo_cnt_nxt;
      if (rd_ret) begin
        fifo_mem[wr_ptr] <= {first_ret, bus_rdata};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_framebuf_pingpong_ctrl.sv
// Directed bench for framebuf_pingpong_ctrl with a latency bus model,
// a memory image of the frame buffer and an output scoreboard.
module tb_framebuf_pingpong_ctrl;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;
  localparam int FP     = 4;
  localparam int RDD    = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic              out_ready = 1'b0;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_write_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_write_done = 1'b0;
  logic              bus_read;
  logic [ADDR_W-1:0] bus_read_addr;
  logic              bus_read_done = 1'b0;
  logic              bus_rvalid = 1'b0;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              wr_bank, rd_bank, err_rvalid;
  logic [15:0]       swap_cnt;

  framebuf_pingpong_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIXELS(FP), .RD_DEPTH(RDD)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_ready(out_ready),
    .bus_write(bus_write), .bus_write_addr(bus_write_addr), .bus_wdata(bus_wdata),
    .bus_write_done(bus_write_done),
    .bus_read(bus_read), .bus_read_addr(bus_read_addr), .bus_read_done(bus_read_done),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .swap_cnt(swap_cnt), .err_rvalid(err_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { logic sof; logic [DATA_W-1:0] data; } px_t;
  typedef struct { int due; logic [DATA_W-1:0] data; } ret_t;

  wr_t wexp[$];
  px_t oexp[$];
  ret_t rq[$];
  wr_t we;
  px_t pe;
  ret_t re;
  logic [DATA_W-1:0] mem [0:7];

  int  n_chk, n_fail, cyc, widx, wframe, nrd, nrd_win, coinc, wcnt, rcnt;
  int  wr_lat, rd_lat, ret_lat;
  bit  coinc_mode, inj, acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe handshakes that complete at the coming posedge.
  task automatic monitor();
    acc = in_valid && in_ready;
    if (acc) begin
      we.addr = ADDR_W'((wframe % 2) * FP + widx);
      we.data = in_data;
      wexp.push_back(we);
      pe.sof  = (widx == 0);
      pe.data = in_data;
      oexp.push_back(pe);
      widx++;
      if (widx == FP) begin widx = 0; wframe++; end
    end
    if (bus_write && bus_write_done) begin
      if (wexp.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        we = wexp.pop_front();
        chk("wr_addr", bus_write_addr, we.addr);
        chk("wr_data", bus_wdata, we.data);
      end
      mem[bus_write_addr[2:0]] = bus_wdata;
    end
    if (bus_read && bus_read_done) begin
      chk("rd_addr", bus_read_addr, ADDR_W'(((nrd / FP) % 2) * FP + nrd % FP));
      re.due  = cyc + ret_lat;
      re.data = mem[bus_read_addr[2:0]];
      rq.push_back(re);
      nrd++;
      nrd_win++;
      if (bus_rvalid) coinc++;
    end
    if (out_valid && out_ready) begin
      if (oexp.size() == 0) chk("out_unexpected", 1, 0);
      else begin
        pe = oexp.pop_front();
        chk("out_px", {out_sof, out_data}, {pe.sof, pe.data});
      end
    end
  endtask

  // Bus responder, driven on the falling edge.
  task automatic bus_model();
    if (bus_write_done) bus_write_done = 1'b0;
    else if (bus_write) begin
      wcnt++;
      if (wcnt >= wr_lat) begin bus_write_done = 1'b1; wcnt = 0; end
    end
    if (bus_read_done) bus_read_done = 1'b0;
    else if (bus_read) begin
      rcnt++;
      if (rcnt >= rd_lat) begin bus_read_done = 1'b1; rcnt = 0; end
    end
    bus_rvalid = 1'b0;
    if (inj) begin
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hDEAD_BEEF;
      inj = 1'b0;
    end else if (rq.size() != 0 &&
                 (coinc_mode ? (bus_read_done || !bus_read) : (rq[0].due <= cyc))) begin
      re = rq.pop_front();
      bus_rvalid = 1'b1;
      bus_rdata  = re.data;
    end
  endtask

  task automatic step();
    #1;
    monitor();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    bus_model();
  endtask

  task automatic send_px(input logic [DATA_W-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin step(); t++; end while (!acc && t < 100);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_swap(input int n);
    int t;
    t = 0;
    while (swap_cnt != 16'(n) && t < 300) begin step(); t++; end
    chk("swap_cnt", swap_cnt, n);
  endtask

  initial begin
    int t;
    n_chk = 0; n_fail = 0; cyc = 0; widx = 0; wframe = 0; nrd = 0; nrd_win = 0;
    coinc = 0; wcnt = 0; rcnt = 0; wr_lat = 2; rd_lat = 2; ret_lat = 3;
    coinc_mode = 0; inj = 0; acc = 0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    @(negedge clk);
    chk("rst_bus_write", bus_write, 0);
    chk("rst_bus_read", bus_read, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_swap_cnt", swap_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err_rvalid, 0);
    step(); step();
    reset_n = 1'b1;
    step();
    out_ready = 1'b1;

    // frame A: write only
    for (int i = 0; i < FP; i++) send_px(32'hA000_0000 + 32'(i));
    t = 0;
    while (swap_cnt == 0 && t < 50) begin chk("in_ready_hold", in_ready, 0); step(); t++; end
    chk("swap1", swap_cnt, 1);
    chk("swap1_wr_bank", wr_bank, 1);
    chk("swap1_rd_bank", rd_bank, 0);

    // frame B written while A streams out
    for (int i = 0; i < FP; i++) send_px(32'hB000_0000 + 32'(i));
    wait_swap(2);
    chk("swap2_rd_bank", rd_bank, 1);
    chk("swap2_wr_bank", wr_bank, 0);

    // downstream backpressure: credits cap in-flight reads
    out_ready = 1'b0;
    nrd_win = 0;
    repeat (20) step();
    chk("bp_reads_le2", nrd_win <= 2, 1);
    chk("bp_bus_read", bus_read, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;

    // slow write completion: request must hold steady
    wr_lat = 10;
    send_px(32'hC000_0000);
    for (int i = 0; i < 8; i++) begin
      chk("stall_wr", bus_write, 1);
      chk("stall_addr", bus_write_addr, 0);
      chk("stall_data", bus_wdata, 32'hC000_0000);
      chk("stall_in_ready", in_ready, 0);
      step();
    end
    wr_lat = 2;

    // returns aligned with the next read-accept
    coinc = 0;
    coinc_mode = 1;
    for (int i = 1; i < FP; i++) send_px(32'hC000_0000 + 32'(i));
    wait_swap(3);
    chk("swap3_rd_bank", rd_bank, 0);
    repeat (40) step();
    coinc_mode = 0;
    chk("coinc_seen", coinc > 0, 1);
    chk("reads_total", nrd, 12);
    chk("sb_drained", oexp.size(), 0);

    // spurious return with nothing outstanding
    chk("err_pre", err_rvalid, 0);
    inj = 1;
    step(); step();
    chk("err_set", err_rvalid, 1);
    chk("err_fifo_empty", out_valid, 0);
    repeat (5) step();
    chk("err_sticky", err_rvalid, 1);

    // frame D, then reset with a write and a read in flight
    rd_lat = 10;
    for (int i = 0; i < FP; i++) send_px(32'hD000_0000 + 32'(i));
    wait_swap(4);
    wr_lat = 10;
    send_px(32'hE000_0000);
    chk("pre_rst_write", bus_write, 1);
    chk("pre_rst_read", bus_read, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_wr_drop", bus_write, 0);
    chk("async_rd_drop", bus_read, 0);
    chk("rst2_swap_cnt", swap_cnt, 0);
    chk("rst2_wr_bank", wr_bank, 0);
    chk("rst2_rd_bank", rd_bank, 1);
    chk("rst2_err", err_rvalid, 0);
    chk("rst2_out_valid", out_valid, 0);
    wexp.delete(); oexp.delete(); rq.delete();
    bus_write_done = 0; bus_read_done = 0; bus_rvalid = 0;
    wcnt = 0; rcnt = 0; widx = 0; wframe = 0; nrd = 0;
    wr_lat = 2; rd_lat = 2;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // writing restarts at address 0 with readout idle
    for (int i = 0; i < FP; i++) begin
      send_px(32'hF000_0000 + 32'(i));
      chk("no_read_after_rst", bus_read, 0);
    end
    wait_swap(1);
    chk("post_rst_wr_bank", wr_bank, 1);
    chk("wr_sb_empty", wexp.size(), 0);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
